// File: rtl/l2_cache_wb.sv
// l2_cache_wb
//   Set-associative, write-back / write-allocate L2 cache with true-LRU
//   replacement and dirty-victim eviction. It handles one request at a time
//   and moves whole blocks to and from both L1 and memory. Writes cover a
//   whole block, so a write miss never reads from memory.
//
// Optional feature macro: L2_STATS_EN
//   When defined, the cache adds the saturating 32-bit counters stat_hits,
//   stat_misses and stat_evicts.
//
// Ports
//   clk, rst_n            clock (posedge), asynchronous active-low reset
//   l1_addr               request word address (offset bits ignored)
//   l1_read / l1_write    request strobes; write wins when both are high
//   l1_wdata              write block, word 0 in the LSBs
//   l1_ready              high in IDLE only
//   l1_resp_valid         one-cycle response pulse
//   l1_resp_hit           1 = hit, 0 = miss serviced (qualified by resp_valid)
//   l1_rdata              read block, or the written block echoed for writes
//   mem_addr, mem_wdata   block address / eviction data, zero when idle
//   mem_read, mem_write   fill / eviction request, held until mem_ready
//   mem_rdata, mem_ready  fill data and completion strobe from memory
//   dbg_state             current FSM state (state_t encoding)
//   stat_*                counters (only with L2_STATS_EN)
//
// Handshake semantics:
//   L1 side:  a request is taken on any rising edge where l1_ready is high
//             and l1_read or l1_write is high. Requests made while l1_ready
//             is low are dropped, not queued. Exactly one l1_resp_valid pulse
//             follows each accepted request.
//   Mem side: mem_read or mem_write (never both) stays high, with mem_addr
//             and mem_wdata held stable, until the first rising edge that
//             has mem_ready high. mem_ready can arrive in the first cycle of
//             the request. mem_ready is ignored while no request is pending.

module l2_cache_wb #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int NUM_SETS    = 16,
  parameter int NUM_WAYS    = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ADDR_WIDTH-1:0]             l1_addr,
  input  logic                              l1_read,
  input  logic                              l1_write,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] l1_wdata,
  output logic                              l1_ready,
  output logic                              l1_resp_valid,
  output logic                              l1_resp_hit,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] l1_rdata,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_wdata,
  output logic                              mem_read,
  output logic                              mem_write,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_rdata,
  input  logic                              mem_ready,
  output logic [2:0]                        dbg_state
`ifdef L2_STATS_EN
  ,
  output logic [31:0]                       stat_hits,
  output logic [31:0]                       stat_misses,
  output logic [31:0]                       stat_evicts
`endif
);

  localparam int BLK_W    = BLOCK_WORDS * DATA_WIDTH;
  localparam int OFFSET_W = $clog2(BLOCK_WORDS);
  localparam int INDEX_W  = $clog2(NUM_SETS);
  localparam int TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;
  localparam int WAY_W    = $clog2(NUM_WAYS);
  localparam int BADDR_W  = ADDR_WIDTH - OFFSET_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_EVICT   = 3'd2,
    S_FILL    = 3'd3,
    S_INSTALL = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t state, state_n;

  // Latched request: only the block address is kept.
  logic [BADDR_W-1:0] req_baddr;
  logic               req_write;
  logic [BLK_W-1:0]   req_wdata;
  logic [WAY_W-1:0]   victim;
  logic [BLK_W-1:0]   fill_buf;
  logic [BLK_W-1:0]   rdata_q;
  logic               hit_q;

  logic [OFFSET_W-1:0] unused_offset;
  assign unused_offset = l1_addr[OFFSET_W-1:0];

  // Cache arrays. Valid, dirty and age bits need a reset value. Tags and
  // data do not, because valid gates every use of them.
  logic [NUM_WAYS-1:0] valid_mem [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_mem [NUM_SETS];
  logic [WAY_W-1:0]    age_mem   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    tag_mem   [NUM_SETS][NUM_WAYS];
  logic [BLK_W-1:0]    data_mem  [NUM_SETS][NUM_WAYS];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  assign idx     = req_baddr[INDEX_W-1:0];
  assign req_tag = req_baddr[BADDR_W-1 -: TAG_W];

  // Tag compare and victim choice for the latched request.
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             have_inv;
  logic [WAY_W-1:0] miss_way;

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    have_inv = 1'b0;
    miss_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_mem[idx][w] && (tag_mem[idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!have_inv && !valid_mem[idx][w]) begin
        have_inv = 1'b1;
        miss_way = WAY_W'(w);
      end
    end
    if (!have_inv) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_mem[idx][w] == WAY_W'(NUM_WAYS - 1)) miss_way = WAY_W'(w);
      end
    end
  end

  logic miss_dirty;
  assign miss_dirty = valid_mem[idx][miss_way] & dirty_mem[idx][miss_way];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state and outputs
  always_comb begin
    state_n       = state;
    l1_ready      = 1'b0;
    l1_resp_valid = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state)
      S_IDLE: begin
        l1_ready = 1'b1;
        if (l1_read || l1_write) state_n = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit)             state_n = S_RESP;
        else if (miss_dirty) state_n = S_EVICT;
        else if (req_write)  state_n = S_INSTALL;
        else                 state_n = S_FILL;
      end
      S_EVICT: begin
        mem_write = 1'b1;
        mem_addr  = {tag_mem[idx][victim], idx, {OFFSET_W{1'b0}}};
        mem_wdata = data_mem[idx][victim];
        if (mem_ready) state_n = req_write ? S_INSTALL : S_FILL;
      end
      S_FILL: begin
        mem_read = 1'b1;
        mem_addr = {req_baddr, {OFFSET_W{1'b0}}};
        if (mem_ready) state_n = S_INSTALL;
      end
      S_INSTALL: state_n = S_RESP;
      S_RESP: begin
        l1_resp_valid = 1'b1;
        state_n       = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign l1_rdata    = rdata_q;
  assign l1_resp_hit = hit_q;
  assign dbg_state   = state;

  // Request and response datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_baddr <= '0;
      req_write <= 1'b0;
      req_wdata <= '0;
      victim    <= '0;
      fill_buf  <= '0;
      rdata_q   <= '0;
      hit_q     <= 1'b0;
    end else begin
      if (state == S_IDLE && (l1_read || l1_write)) begin
        req_baddr <= l1_addr[ADDR_WIDTH-1:OFFSET_W];
        req_write <= l1_write;
        req_wdata <= l1_wdata;
      end
      if (state == S_LOOKUP) begin
        victim <= miss_way;
        if (hit) begin
          hit_q   <= 1'b1;
          rdata_q <= req_write ? req_wdata : data_mem[idx][hit_way];
        end
      end
      if (state == S_FILL && mem_ready) fill_buf <= mem_rdata;
      if (state == S_INSTALL) begin
        hit_q   <= 1'b0;
        rdata_q <= req_write ? req_wdata : fill_buf;
      end
    end
  end

  // The LRU ages are updated on a hit (in LOOKUP) and on every install.
  logic             lru_upd;
  logic [WAY_W-1:0] lru_way;
  assign lru_upd = ((state == S_LOOKUP) && hit) || (state == S_INSTALL);
  assign lru_way = (state == S_LOOKUP) ? hit_way : victim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_mem[s][w] <= WAY_W'(w);
      end
    end else begin
      if (state == S_EVICT && mem_ready) valid_mem[idx][victim] <= 1'b0;
      if (state == S_LOOKUP && hit && req_write) dirty_mem[idx][hit_way] <= 1'b1;
      if (state == S_INSTALL) begin
        valid_mem[idx][victim] <= 1'b1;
        dirty_mem[idx][victim] <= req_write;
      end
      if (lru_upd) begin
        // Ways younger than the accessed way age by one, and the accessed
        // way becomes the youngest. The ages stay a permutation.
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (age_mem[idx][w] < age_mem[idx][lru_way])
            age_mem[idx][w] <= age_mem[idx][w] + WAY_W'(1);
        end
        age_mem[idx][lru_way] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_LOOKUP && hit && req_write) data_mem[idx][hit_way] <= req_wdata;
    if (state == S_INSTALL) begin
      tag_mem[idx][victim]  <= req_tag;
      data_mem[idx][victim] <= req_write ? req_wdata : fill_buf;
    end
  end

`ifdef L2_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_evicts <= '0;
    end else begin
      if (state == S_RESP) begin
        if (hit_q) begin
          if (stat_hits != 32'hFFFF_FFFF) stat_hits <= stat_hits + 32'd1;
        end else begin
          if (stat_misses != 32'hFFFF_FFFF) stat_misses <= stat_misses + 32'd1;
        end
      end
      if (state == S_EVICT && mem_ready && stat_evicts != 32'hFFFF_FFFF)
        stat_evicts <= stat_evicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_cache_wb.sv
// tb_l2_cache_wb
//   Directed bench for l2_cache_wb. Driver tasks issue L1 requests and act
//   as main memory. Expected responses go into exp_q, and a monitor on the
//   falling edge pops them and compares them with each l1_resp_valid pulse.
//   The monitor also checks the memory-side invariants on every cycle.

module tb_l2_cache_wb;

  localparam int BLK_W = 256;

  logic             clk;
  logic             rst_n;
  logic [15:0]      l1_addr;
  logic             l1_read;
  logic             l1_write;
  logic [BLK_W-1:0] l1_wdata;
  logic             l1_ready;
  logic             l1_resp_valid;
  logic             l1_resp_hit;
  logic [BLK_W-1:0] l1_rdata;
  logic [15:0]      mem_addr;
  logic [BLK_W-1:0] mem_wdata;
  logic             mem_read;
  logic             mem_write;
  logic [BLK_W-1:0] mem_rdata;
  logic             mem_ready;
  logic [2:0]       dbg_state;
`ifdef L2_STATS_EN
  logic [31:0]      stat_hits, stat_misses, stat_evicts;
`endif

  l2_cache_wb dut (
    .clk(clk), .rst_n(rst_n),
    .l1_addr(l1_addr), .l1_read(l1_read), .l1_write(l1_write), .l1_wdata(l1_wdata),
    .l1_ready(l1_ready), .l1_resp_valid(l1_resp_valid), .l1_resp_hit(l1_resp_hit),
    .l1_rdata(l1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .dbg_state(dbg_state)
`ifdef L2_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_evicts(stat_evicts)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [BLK_W:0] exp_q[$];
  int checks     = 0;
  int failures   = 0;
  int resp_cnt   = 0;
  int resp_cyc   = 0;
  int mem_rd_cyc = 0;
  int mem_wr_cyc = 0;

  function automatic logic [BLK_W-1:0] mk_blk(input logic [31:0] base);
    logic [BLK_W-1:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = base + 32'(i);
    return b;
  endfunction

  task automatic check(input string name, input logic [BLK_W-1:0] act,
                       input logic [BLK_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("mem_exclusive", BLK_W'(mem_read & mem_write), '0);
      if (!mem_read && !mem_write) begin
        check("mem_idle_addr", BLK_W'(mem_addr), '0);
        check("mem_idle_wdata", mem_wdata, '0);
      end
      if (mem_read)  mem_rd_cyc++;
      if (mem_write) mem_wr_cyc++;
      if (l1_resp_valid) begin
        resp_cnt++;
        resp_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected actual=hit%0d required=no_response", l1_resp_hit);
        end else begin
          logic [BLK_W:0] e;
          e = exp_q.pop_front();
          check("resp_hit", BLK_W'(l1_resp_hit), BLK_W'(e[BLK_W]));
          check("resp_data", l1_rdata, e[BLK_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic issue(input logic [15:0] addr, input bit wr, input logic [BLK_W-1:0] wdata,
                       input bit exp_hit, input logic [BLK_W-1:0] exp_data, input bit push,
                       output int acc_cyc);
    int n;
    n = 0;
    while (!l1_ready && n < 100) begin
      tick();
      n++;
    end
    if (!l1_ready) timeout_fail("wait_ready");
    l1_addr  = addr;
    l1_wdata = wdata;
    l1_write = wr;
    l1_read  = !wr;
    acc_cyc  = cyc;
    if (push) exp_q.push_back({exp_hit, exp_data});
    tick();
    l1_read  = 1'b0;
    l1_write = 1'b0;
  endtask

  task automatic l1_req(input logic [15:0] addr, input bit wr, input logic [BLK_W-1:0] wdata,
                        input bit exp_hit, input logic [BLK_W-1:0] exp_data, input int exp_lat);
    int n0, acc, n;
    n0 = resp_cnt;
    issue(addr, wr, wdata, exp_hit, exp_data, 1'b1, acc);
    n = 0;
    while (resp_cnt == n0 && n < 200) begin
      tick();
      n++;
    end
    if (resp_cnt == n0) timeout_fail("wait_resp");
    else if (exp_lat >= 0) check("latency", BLK_W'(resp_cyc - acc), BLK_W'(exp_lat));
  endtask

  task automatic wait_mem(input bit is_wr, output bit ok);
    int n;
    n = 0;
    while (!(is_wr ? mem_write : mem_read) && n < 100) begin
      tick();
      n++;
    end
    ok = is_wr ? mem_write : mem_read;
    if (!ok) timeout_fail(is_wr ? "wait_mem_write" : "wait_mem_read");
  endtask

  task automatic mem_serve_read(input logic [15:0] exp_addr, input logic [31:0] base,
                                input int delay);
    bit ok, stable;
    wait_mem(1'b0, ok);
    if (ok) begin
      check("fill_addr", BLK_W'(mem_addr), BLK_W'(exp_addr));
      stable = 1'b1;
      for (int d = 0; d < delay; d++) begin
        tick();
        if (!mem_read || mem_addr !== exp_addr) stable = 1'b0;
      end
      if (delay > 0) check("fill_held", BLK_W'(stable), BLK_W'(1));
      mem_rdata = mk_blk(base);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
    end
  endtask

  task automatic mem_serve_write(input logic [15:0] exp_addr, input logic [BLK_W-1:0] exp_data,
                                 input int delay);
    bit ok;
    wait_mem(1'b1, ok);
    if (ok) begin
      check("evict_addr", BLK_W'(mem_addr), BLK_W'(exp_addr));
      check("evict_data", mem_wdata, exp_data);
      for (int d = 0; d < delay; d++) tick();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
    end
  endtask

  // ---------------- directed sequence ----------------
  int  rd0, wr0, n0;
  bit  ok;
  int  acc;

  initial begin
    rst_n = 1'b0; l1_addr = '0; l1_read = 1'b0; l1_write = 1'b0; l1_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (3) tick();
    check("rst_ready", BLK_W'(l1_ready), BLK_W'(1));
    check("rst_resp_valid", BLK_W'(l1_resp_valid), '0);
    check("rst_resp_hit", BLK_W'(l1_resp_hit), '0);
    check("rst_rdata", l1_rdata, '0);
    check("rst_mem_rw", BLK_W'({mem_read, mem_write}), '0);
    check("rst_mem_addr", BLK_W'(mem_addr), '0);
    check("rst_state", BLK_W'(dbg_state), '0);
    rst_n = 1'b1;
    tick();

    // 1: read miss with fill, then a hit with latency 2
    fork
      l1_req(16'h0040, 1'b0, '0, 1'b0, mk_blk(32'h100), 4);
      mem_serve_read(16'h0040, 32'h100, 0);
    join
    l1_req(16'h0040, 1'b0, '0, 1'b1, mk_blk(32'h100), 2);

    // a stray mem_ready while idle must be ignored
    n0 = resp_cnt;
    mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    tick();
    check("stray_ready_idle", BLK_W'(l1_ready), BLK_W'(1));
    check("stray_ready_resp", BLK_W'(resp_cnt - n0), '0);

    // 2: write miss allocates without any memory traffic
    rd0 = mem_rd_cyc; wr0 = mem_wr_cyc;
    l1_req(16'h0080, 1'b1, mk_blk(32'hA0), 1'b0, mk_blk(32'hA0), 3);
    check("wmiss_no_mem", BLK_W'((mem_rd_cyc - rd0) + (mem_wr_cyc - wr0)), '0);
    l1_req(16'h0080, 1'b0, '0, 1'b1, mk_blk(32'hA0), 2);

    // 3: five writes into set 0; the fifth evicts dirty 0x0000
    l1_req(16'h0000, 1'b1, mk_blk(32'h1000), 1'b0, mk_blk(32'h1000), 3);
    l1_req(16'h0080, 1'b1, mk_blk(32'h1080), 1'b1, mk_blk(32'h1080), 2);
    l1_req(16'h0100, 1'b1, mk_blk(32'h1100), 1'b0, mk_blk(32'h1100), 3);
    l1_req(16'h0180, 1'b1, mk_blk(32'h1180), 1'b0, mk_blk(32'h1180), 3);
    rd0 = mem_rd_cyc; wr0 = mem_wr_cyc;
    fork
      l1_req(16'h0200, 1'b1, mk_blk(32'h1200), 1'b0, mk_blk(32'h1200), 4);
      mem_serve_write(16'h0000, mk_blk(32'h1000), 0);
    join
    check("evict_no_fill", BLK_W'(mem_rd_cyc - rd0), '0);
    check("evict_one_cycle", BLK_W'(mem_wr_cyc - wr0), BLK_W'(1));

    // 5: reset during EVICT (victim is dirty 0x0080)
    issue(16'h0280, 1'b0, '0, 1'b0, '0, 1'b0, acc);
    wait_mem(1'b1, ok);
    if (ok) begin
      check("evict2_addr", BLK_W'(mem_addr), BLK_W'(16'h0080));
      check("evict2_data", mem_wdata, mk_blk(32'h1080));
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_mem_write", BLK_W'(mem_write), '0);
    check("rst_mid_mem_addr", BLK_W'(mem_addr), '0);
    check("rst_mid_mem_wdata", mem_wdata, '0);
    check("rst_mid_ready", BLK_W'(l1_ready), BLK_W'(1));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    wr0 = mem_wr_cyc;
    fork
      l1_req(16'h0040, 1'b0, '0, 1'b0, mk_blk(32'h5040), 4);
      mem_serve_read(16'h0040, 32'h5040, 0);
    join
    fork
      l1_req(16'h0000, 1'b0, '0, 1'b0, mk_blk(32'h5000), 4);
      mem_serve_read(16'h0000, 32'h5000, 0);
    join
    check("post_rst_no_wb", BLK_W'(mem_wr_cyc - wr0), '0);

    // 4: fill set 0 by reads, touch 0x0000, read 0x0200 -> clean victim 0x0080
    l1_req(16'h0000, 1'b0, '0, 1'b1, mk_blk(32'h5000), 2);
    fork
      l1_req(16'h0080, 1'b0, '0, 1'b0, mk_blk(32'h4080), 4);
      mem_serve_read(16'h0080, 32'h4080, 0);
    join
    fork
      l1_req(16'h0100, 1'b0, '0, 1'b0, mk_blk(32'h4100), 4);
      mem_serve_read(16'h0100, 32'h4100, 0);
    join
    fork
      l1_req(16'h0180, 1'b0, '0, 1'b0, mk_blk(32'h4180), 4);
      mem_serve_read(16'h0180, 32'h4180, 0);
    join
    l1_req(16'h0000, 1'b0, '0, 1'b1, mk_blk(32'h5000), 2);
    wr0 = mem_wr_cyc;
    fork
      l1_req(16'h0200, 1'b0, '0, 1'b0, mk_blk(32'h4200), 4);
      mem_serve_read(16'h0200, 32'h4200, 0);
    join
    check("clean_victim_no_wb", BLK_W'(mem_wr_cyc - wr0), '0);
    l1_req(16'h0000, 1'b0, '0, 1'b1, mk_blk(32'h5000), 2);
    fork
      l1_req(16'h0080, 1'b0, '0, 1'b0, mk_blk(32'h4880), 4);
      mem_serve_read(16'h0080, 32'h4880, 0);
    join
    l1_req(16'h0180, 1'b0, '0, 1'b1, mk_blk(32'h4180), 2);

    // 6: slow memory (7 wait cycles) with a dropped request while busy
    rd0 = mem_rd_cyc; n0 = resp_cnt;
    fork
      l1_req(16'h0300, 1'b0, '0, 1'b0, mk_blk(32'h6300), -1);
      mem_serve_read(16'h0300, 32'h6300, 7);
      begin
        bit got;
        wait_mem(1'b0, got);
        tick();
        l1_addr = 16'h0500;
        l1_read = 1'b1;
        check("busy_not_ready", BLK_W'(l1_ready), '0);
        repeat (2) tick();
        l1_read = 1'b0;
      end
    join
    repeat (6) tick();
    check("busy_req_dropped", BLK_W'(resp_cnt - n0), BLK_W'(1));
    check("slow_fill_cycles", BLK_W'(mem_rd_cyc - rd0), BLK_W'(8));
    check("queue_empty", BLK_W'(exp_q.size()), '0);
    fork
      l1_req(16'h0500, 1'b0, '0, 1'b0, mk_blk(32'h6500), 4);
      mem_serve_read(16'h0500, 32'h6500, 0);
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
